// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner: raw active-low pins in,
// debounced active-high levels and one-cycle press/release pulses out.
interface button_conditioner_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (output btn_raw, input btn_level, input btn_press, input btn_release);
    modport slave  (input btn_raw, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/button_conditioner.sv
// Per-channel 2-FF synchroniser, debounce FSM and press/release edge pulses for push buttons.
// Optional auto-repeat of btn_press while held is built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_START    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    // state      | meaning
    // REL        | released, committed level 0
    // PRESS_PEND | pin reads pressed, counting stable cycles before committing
    // PRS        | pressed, committed level 1
    // REL_PEND   | pin reads released, counting stable cycles before committing
    typedef enum logic [1:0] {REL, PRESS_PEND, PRS, REL_PEND} state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_START < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_START and REPEAT_PERIOD must be >= 1");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_START + REPEAT_PERIOD + 1);
    localparam logic [HOLD_W-1:0] START_LAST = HOLD_W'(REPEAT_START - 1);
    localparam logic [HOLD_W-1:0] REP_LAST   = HOLD_W'(REPEAT_PERIOD - 1);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             sync1, sync2, s;
        logic             level_r, press_r, release_r;
`ifdef BTN_AUTOREPEAT_EN
        logic [HOLD_W-1:0] hold;
        logic              rep_phase;  // 0: waiting for first repeat, 1: periodic repeats
`endif

        assign s = ~sync2;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1     <= 1'b1;
                sync2     <= 1'b1;
                state     <= REL;
                cnt       <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                hold      <= '0;
                rep_phase <= 1'b0;
`endif
            end else begin
                sync1     <= bus.btn_raw[i];
                sync2     <= sync1;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                case (state)
                    REL: begin
                        if (s) begin
                            state <= PRESS_PEND;
                            cnt   <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_PEND: begin
                        if (!s) begin
                            state <= REL;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state   <= PRS;
                            cnt     <= '0;
                            level_r <= 1'b1;
                            press_r <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            hold      <= '0;
                            rep_phase <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRS: begin
                        if (!s) begin
                            state <= REL_PEND;
                            cnt   <= CNT_W'(1);
                        end
`ifdef BTN_AUTOREPEAT_EN
                        else if (hold == (rep_phase ? REP_LAST : START_LAST)) begin
                            press_r   <= 1'b1;
                            hold      <= '0;
                            rep_phase <= 1'b1;
                        end else begin
                            hold <= hold + HOLD_W'(1);
                        end
`endif
                    end
                    REL_PEND: begin
                        // hold counter stays frozen here so a release glitch resumes the repeat timing
                        if (s) begin
                            state <= PRS;
                            cnt   <= '0;
                        end else if (cnt == CNT_MAX) begin
                            state     <= REL;
                            cnt       <= '0;
                            level_r   <= 1'b0;
                            release_r <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            hold      <= '0;
                            rep_phase <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= REL;
                endcase
            end
        end

        assign bus.btn_level[i]   = level_r;
        assign bus.btn_press[i]   = press_r;
        assign bus.btn_release[i] = release_r;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random pin activity,
// all compared against a run-length reference model of the debounce rules.
module tb_button_conditioner;
    localparam int NB = 3;
    localparam int DB = 4;
    localparam int RS = 20;
    localparam int RP = 5;
    localparam int LAT = DB + 3;  // tick index (1 = first low sample) where the commit is visible

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_conditioner_if #(.NUM_BTN(NB)) bif();

    button_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_START(RS), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a level flips once the synchronised sample has disagreed with it
    // for DB+1 consecutive edges; the hold count advances only on steady pressed edges.
    logic [NB-1:0] m_sync1 = '1, m_sync2 = '1, m_level = '0, m_press = '0, m_release = '0, m_sprev = '0;
    int m_run[NB];
`ifdef BTN_AUTOREPEAT_EN
    int m_hold[NB];
`endif

    function automatic void model_edge();
        logic s;
        if (reset) begin
            m_sync1 = '1; m_sync2 = '1; m_level = '0; m_press = '0; m_release = '0; m_sprev = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                m_hold[i] = 0;
`endif
            end
        end else begin
            m_press = '0; m_release = '0;
            for (int i = 0; i < NB; i++) begin
                s = ~m_sync2[i];
                if (s != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB + 1) begin
                        m_level[i] = s;
                        if (s) m_press[i] = 1'b1; else m_release[i] = 1'b1;
                        m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                        m_hold[i] = 0;
`endif
                    end
                end else begin
                    m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                    if (s && m_sprev[i]) begin
                        m_hold[i]++;
                        if (m_hold[i] == RS || (m_hold[i] > RS && (m_hold[i] - RS) % RP == 0))
                            m_press[i] = 1'b1;
                    end
`endif
                end
                m_sprev[i] = s;
            end
            m_sync2 = m_sync1;
            m_sync1 = bif.btn_raw;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        bif.btn_raw = '1;
        reset = 1'b1;
        settle(3);
        checks++;
        if (bif.btn_level !== 3'b000 || bif.btn_press !== 3'b000 || bif.btn_release !== 3'b000) begin
            errors++;
            $display("FAIL reset_state lvl=%b prs=%b rel=%b required all 000",
                     bif.btn_level, bif.btn_press, bif.btn_release);
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (bif.btn_press !== 3'b000 || bif.btn_release !== 3'b000 || bif.btn_level !== m_level) begin
                errors++;
                $display("FAIL reset_exit k=%0d prs=%b rel=%b lvl=%b required prs=000 rel=000 lvl=%b",
                         k, bif.btn_press, bif.btn_release, bif.btn_level, m_level);
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1, npress = 0, other = 0;
        bif.btn_raw[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (bif.btn_level !== m_level || bif.btn_press !== m_press || bif.btn_release !== m_release) begin
                errors++;
                $display("FAIL clean_press_model k=%0d got %b/%b/%b required %b/%b/%b", k,
                         bif.btn_level, bif.btn_press, bif.btn_release, m_level, m_press, m_release);
            end
            if (bif.btn_press[0]) begin
                npress++;
                if (first < 0) first = k;
            end
            if (bif.btn_press[2:1] != 2'b00 || bif.btn_level[2:1] != 2'b00) other++;
        end
        checks++;
        if (first != LAT || npress != 1 || bif.btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL clean_press_latency at=%0d pulses=%0d lvl=%b required at=%0d pulses=1 lvl=1",
                     first, npress, bif.btn_level[0], LAT);
        end
        checks++;
        if (other != 0) begin
            errors++;
            $display("FAIL clean_press_isolation got %0d disturbed cycles required 0", other);
        end
        bif.btn_raw[0] = 1'b1;
        settle(12);
        checks++;
        if (bif.btn_level !== 3'b000) begin
            errors++;
            $display("FAIL clean_press_release lvl=%b required 000", bif.btn_level);
        end
    endtask

    task automatic test_bounce();
        int seen = 0;
        logic pat [15] = '{0,0,0,1,0,0,0,1,1,1,1,1,1,1,1};
        for (int k = 0; k < 15; k++) begin
            bif.btn_raw[1] = pat[k];
            tick();
            checks++;
            if (bif.btn_level !== m_level || bif.btn_press !== m_press || bif.btn_release !== m_release) begin
                errors++;
                $display("FAIL bounce_model k=%0d got %b/%b/%b required %b/%b/%b", k,
                         bif.btn_level, bif.btn_press, bif.btn_release, m_level, m_press, m_release);
            end
            if (bif.btn_press[1] || bif.btn_level[1]) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL bounce_reject got %0d active cycles on ch1 required 0", seen);
        end
    endtask

    task automatic test_release();
        int at = -1, nrel = 0;
        bif.btn_raw[2] = 1'b0;
        settle(10);
        checks++;
        if (bif.btn_level !== 3'b100) begin
            errors++;
            $display("FAIL release_setup lvl=%b required 100", bif.btn_level);
        end
        bif.btn_raw[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bif.btn_release[2]) begin
                nrel++;
                if (at < 0) at = k;
            end
            if (k == LAT) begin
                checks++;
                if (bif.btn_level[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL release_level lvl=%b required 0", bif.btn_level[2]);
                end
            end
            if (k == LAT - 1) begin
                checks++;
                if (bif.btn_level[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL release_early lvl=%b required 1", bif.btn_level[2]);
                end
            end
        end
        checks++;
        if (at != LAT || nrel != 1) begin
            errors++;
            $display("FAIL release_pulse at=%0d pulses=%0d required at=%0d pulses=1", at, nrel, LAT);
        end
    endtask

    task automatic test_simultaneous();
        int at = -1, n = 0;
        bif.btn_raw = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bif.btn_press != 3'b000) begin
                n++;
                if (at < 0) at = k;
                checks++;
                if (bif.btn_press !== 3'b111 || bif.btn_level !== 3'b111) begin
                    errors++;
                    $display("FAIL simultaneous_pulse prs=%b lvl=%b required 111/111",
                             bif.btn_press, bif.btn_level);
                end
            end
        end
        checks++;
        if (at != LAT || n != 1) begin
            errors++;
            $display("FAIL simultaneous_timing at=%0d cycles=%0d required at=%0d cycles=1", at, n, LAT);
        end
        bif.btn_raw = 3'b111;
        settle(12);
    endtask

    task automatic test_reset_mid();
        int at = -1, other = 0;
        bif.btn_raw[0] = 1'b0;
        settle(4);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bif.btn_level !== 3'b000 || bif.btn_press !== 3'b000 || bif.btn_release !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_hold k=%0d got %b/%b/%b required 000/000/000", k,
                         bif.btn_level, bif.btn_press, bif.btn_release);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bif.btn_press[0] && at < 0) at = k;
            if (bif.btn_press[2:1] != 2'b00 || bif.btn_release != 3'b000) other++;
        end
        checks++;
        if (at != LAT || other != 0) begin
            errors++;
            $display("FAIL reset_mid_resume at=%0d stray=%0d required at=%0d stray=0", at, other, LAT);
        end
        bif.btn_raw[0] = 1'b1;
        settle(12);
    endtask

    task automatic test_autorepeat();
        int commit = -1;
        int got[$];
        int exp_q[$];
`ifdef BTN_AUTOREPEAT_EN
        exp_q = '{0, RS, RS + RP, RS + 2 * RP, RS + 3 * RP};
`else
        exp_q = '{0};
`endif
        bif.btn_raw[0] = 1'b0;
        for (int k = 1; k <= LAT + 38; k++) begin
            tick();
            checks++;
            if (bif.btn_press !== m_press || bif.btn_level !== m_level) begin
                errors++;
                $display("FAIL autorepeat_model k=%0d prs=%b lvl=%b required %b/%b", k,
                         bif.btn_press, bif.btn_level, m_press, m_level);
            end
            if (bif.btn_press[0]) begin
                if (commit < 0) commit = k;
                got.push_back(k - commit);
            end
        end
        checks++;
        if (got != exp_q) begin
            errors++;
            $display("FAIL autorepeat_pulses got %p required %p", got, exp_q);
        end
        bif.btn_raw[0] = 1'b1;
        settle(12);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 7) == 0) bif.btn_raw[i] = ~bif.btn_raw[i];
            reset = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if (bif.btn_level !== m_level || bif.btn_press !== m_press || bif.btn_release !== m_release ||
                (bif.btn_press & bif.btn_release) != 3'b000) begin
                errors++;
                $display("FAIL random k=%0d raw=%b got %b/%b/%b required %b/%b/%b", k, bif.btn_raw,
                         bif.btn_level, bif.btn_press, bif.btn_release, m_level, m_press, m_release);
            end
        end
        reset = 1'b0;
        bif.btn_raw = '1;
        settle(12);
    endtask

    initial begin
        bif.btn_raw = '1;
        for (int i = 0; i < NB; i++) begin
            m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
            m_hold[i] = 0;
`endif
        end
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
